// File: rtl/pipe_pkg.sv
// Shared pipeline constants: result-select codes, forwarding selects, multi-cycle op prefix.
// Also holds the forwarding-select helper and the multi-cycle FSM state type.
// Pure declarations; no logic, no latency, no flow control.
package pipe_pkg;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // ALUControlE[3:2] value that marks a multi-cycle (mul/div) op
    localparam logic [1:0] MD_OP_PREFIX = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Operand source for one EX source register; MEM result wins over WB,
    // and x0 is never forwarded because it always reads as zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end else begin
            return FWD_NONE;
        end
    endfunction

endpackage

// File: rtl/md_stall_fsm.sv
// Multi-cycle op tracker: keeps an op in EX for MD_LAT cycles, mdStall high for MD_LAT-1.
// Latency: mdStall is combinational from mdop and state; asserts the cycle the op arrives.
// Backpressure: mdStall is the stall itself; drops for one release cycle between ops.
module md_stall_fsm
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mdop,
    output logic mdStall
);

    // First cycle is spent in IDLE, last one is the release cycle.
    localparam logic [3:0] CNT_LOAD = 4'(MD_LAT - 2);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // State and down-counter registers; reset abandons any op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and stall output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mdStall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdop) begin
                    mdStall = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    mdStall = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        if (reset) begin
            mdStall = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use stall, branch flush, mul/div stall.
// Latency: all outputs combinational from inputs and multi-cycle FSM state (zero cycles).
// Backpressure: StallF/StallD hold front end; StallE/FlushM freeze EX during multi-cycle ops.
// Optional: define HAZARD_MULDIV_EN to include the multi-cycle op FSM (md_stall_fsm).
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic [3:0] ALUControlE,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       StallE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    logic md_stall;
    logic lw_stall;
    logic unused_alu_lo;

    // Only the op-class bits of the ALU control matter here.
    assign unused_alu_lo = ^ALUControlE[1:0];

`ifdef HAZARD_MULDIV_EN
    logic mdop;

    assign mdop = (ALUControlE[3:2] == MD_OP_PREFIX);

    md_stall_fsm #(
        .MD_LAT (MD_LAT)
    ) u_md_stall_fsm (
        .clk     (clk),
        .reset   (reset),
        .mdop    (mdop),
        .mdStall (md_stall)
    );
`else
    logic unused_md;

    // Without the multi-cycle unit every op completes in one EX cycle.
    assign md_stall  = 1'b0;
    assign unused_md = ^{clk, ALUControlE[3:2], 5'(MD_LAT)};
`endif

    // Load-use detection, forwarding selects and stall/flush combination;
    // everything is held at zero while reset is asserted.
    always_comb begin
        lw_stall  = (ResultSrcE == RESULTSRC_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        StallE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;
        if (!reset) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            StallF    = lw_stall | md_stall;
            StallD    = lw_stall | md_stall;
            StallE    = md_stall;
            FlushM    = md_stall;
            FlushD    = PCSrcE;
            // A frozen EX stage must not be cleared underneath the running op.
            FlushE    = (lw_stall | PCSrcE) & ~md_stall;
        end
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
- REQ-001 SHALL provide parameter MD_LAT, default 4, meaning total EX-stage occupancy in cycles of a multi-cycle op; legal range 2..16.
- REQ-002 SHALL have port clk, input, 1 bit, clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
- REQ-004 SHALL have ports Rs1D and Rs2D, input, 5 bits each, source registers of the instruction in ID.
- REQ-005 SHALL have ports Rs1E, Rs2E and RdE, input, 5 bits each, register fields of the instruction in EX.
- REQ-006 SHALL have ports ResultSrcE (input, 2 bits, EX result select; 2'b01 = load), ALUControlE (input, 4 bits, EX ALU op) and PCSrcE (input, 1 bit, branch/jump taken in EX).
- REQ-007 SHALL have ports RdM (input, 5 bits), RegWriteM (input, 1 bit), RdW (input, 5 bits) and RegWriteW (input, 1 bit).
- REQ-008 SHALL have ports StallF and StallD (output, 1 bit each), which hold the PC and the IF/ID register.
- REQ-009 SHALL have ports FlushD (output, 1 bit, clears IF/ID) and FlushE (output, 1 bit, drives the clear input of the ID/EX register).
- REQ-010 SHALL have ports StallE (output, 1 bit, holds ID/EX) and FlushM (output, 1 bit, bubble into EX/MEM).
- REQ-011 SHALL have ports ForwardAE and ForwardBE, output, 2 bits each, EX operand source select.

Function
- REQ-012 SHALL set ForwardAE to 2'b10 when RegWriteM is 1, RdM is nonzero and RdM equals Rs1E.
- REQ-013 SHALL otherwise set ForwardAE to 2'b01 when RegWriteW is 1, RdW is nonzero and RdW equals Rs1E; otherwise 2'b00.
- REQ-014 SHALL apply the same rules to ForwardBE using Rs2E; the MEM source has priority over WB.
- REQ-015 SHALL compute lwStall as: ResultSrcE equals 2'b01, RdE is nonzero, and RdE equals Rs1D or Rs2D.
- REQ-016 SHALL classify an op as multi-cycle (mdop) when ALUControlE[3:2] equals 2'b11.
- REQ-017 SHALL implement an FSM with states IDLE and BUSY and a 4-bit down-counter cnt.
- REQ-018 In IDLE with mdop, SHALL assert mdStall that same cycle, go to BUSY, and load cnt with MD_LAT-2.
- REQ-019 In BUSY, SHALL assert mdStall while cnt is nonzero and decrement cnt each cycle.
- REQ-020 In BUSY with cnt at zero, SHALL deassert mdStall and return to IDLE; this is the release cycle.
- REQ-021 As a result of REQ-018 to REQ-020, SHALL hold the op in EX for exactly MD_LAT cycles with mdStall high for MD_LAT-1 of them.
- REQ-022 After a release, SHALL re-enter BUSY on the next cycle if a new mdop is in EX in IDLE (back-to-back ops).
- REQ-023 SHALL drive StallF and StallD as lwStall OR mdStall, and StallE and FlushM as mdStall.
- REQ-024 SHALL drive FlushD as PCSrcE, and FlushE as (lwStall OR PCSrcE) AND NOT mdStall.
- REQ-025 All outputs SHALL be combinational from the inputs, the FSM state and cnt; no output adds latency.

Reset
- REQ-026 While reset is high, SHALL force state to IDLE, cnt to 0, all stall/flush outputs to 0 and ForwardAE/ForwardBE to 2'b00.
- REQ-027 On reset asserted mid-BUSY, SHALL abandon the op; after release, an mdop still in EX SHALL restart from IDLE.

Configuration
- REQ-028 With HAZARD_MULDIV_EN defined, SHALL include the FSM, counter and mdStall logic.
- REQ-029 Without HAZARD_MULDIV_EN, SHALL tie mdStall, StallE and FlushM to 0, instantiate no FSM, and leave forwarding and load-use logic unchanged.

Structure
- REQ-030 SHALL take from shared package pipe_pkg: RESULTSRC_LOAD (2'b01), FWD_NONE/FWD_WB/FWD_MEM (00/01/10), and the MD_OP_PREFIX constant (2'b11).
- REQ-031 SHALL place the FSM and counter in sub-module md_stall_fsm (ports clk, reset, mdop, mdStall), instantiated only under HAZARD_MULDIV_EN.

Verification
- REQ-032 Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; same with RdM=0 -> ForwardAE=01.
- REQ-033 Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0; with RdE=0 -> all 0.
- REQ-034 Branch: PCSrcE=1, no mdop -> FlushD=FlushE=1, StallF=0.
- REQ-035 Multi-cycle op, MD_LAT=4, ALUControlE=4'b1100 held -> StallE=FlushM=1 for cycles 0-2 and 0 in cycle 3; with an mdop still present, stall re-asserts in cycle 4.
- REQ-036 Reset pulse in cycle 1 of a BUSY sequence -> outputs 0 during reset, FSM in IDLE; after release the mdop restarts with MD_LAT-1 stall cycles.
- REQ-037 Build without HAZARD_MULDIV_EN, ALUControlE=4'b1100 -> StallE=FlushM=0 every cycle.
